// File: rtl/operand_streamer.sv
// Operand streamer: answers a read request by sweeping one tile out of local SRAM
// and presenting each word diagonally skewed across ROWS lanes for the array edge.
module operand_streamer #(
   parameter int DATA_W = 8,
   parameter int ROWS   = 4,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     read,
   input  logic                     clr,
   output logic                     mem_en,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic [ROWS*DATA_W-1:0]   mem_rdata,
   output logic [ROWS*DATA_W-1:0]   out_data,
   output logic [ROWS-1:0]          out_valid,
   output logic                     done,
   output logic                     busy
);

   localparam int CNT_W = (ROWS > 0) ? $clog2(ROWS + 1) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              rvld;
   logic              flush;

   // A clear, or the request dropping mid-pass, empties the whole pipeline in one cycle.
   assign flush = clr || (((state == FETCH) || (state == DRAIN)) && !read);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         mem_en   <= 1'b0;
         mem_addr <= '0;
         done     <= 1'b0;
         busy     <= 1'b0;
         cnt      <= '0;
         rvld     <= 1'b0;
      end else begin
         done <= 1'b0;
         rvld <= mem_en;
         if (flush) begin
            state    <= IDLE;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            cnt      <= '0;
            rvld     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (read) begin
                     state    <= FETCH;
                     mem_en   <= 1'b1;
                     mem_addr <= '0;
                     busy     <= 1'b1;
                     cnt      <= '0;
                  end
               end
               FETCH: begin
                  if (mem_addr == ADDR_W'(DEPTH - 1)) begin
                     state    <= DRAIN;
                     mem_en   <= 1'b0;
                     mem_addr <= '0;
                  end else begin
                     mem_addr <= mem_addr + 1'b1;
                  end
               end
               DRAIN: begin
                  // ROWS+1 drain cycles: one for the SRAM read stage, ROWS for the skew.
                  if (cnt == CNT_W'(ROWS)) begin
                     state <= HOLD;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               HOLD: begin
                  if (!read) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Lane i carries i+1 registers: one to capture the SRAM word, i more for the skew.
   for (genvar i = 0; i < ROWS; i++) begin : g_lane
      logic [DATA_W-1:0] sd [0:i];
      logic [i:0]        sv;

      always_ff @(posedge clk or posedge rst) begin
         if (rst || flush) begin
            if (rst) begin
               for (int j = 0; j <= i; j++) sd[j] <= '0;
               sv <= '0;
            end else begin
               for (int j = 0; j <= i; j++) sd[j] <= '0;
               sv <= '0;
            end
         end else begin
            sd[0] <= rvld ? mem_rdata[i*DATA_W +: DATA_W] : '0;
            sv[0] <= rvld;
            for (int j = 1; j <= i; j++) begin
               sd[j] <= sd[j-1];
               sv[j] <= sv[j-1];
            end
         end
      end

      assign out_data[i*DATA_W +: DATA_W] = sd[i];
      assign out_valid[i]                 = sv[i];
   end

endmodule

// File: tb/tb_operand_streamer.sv
// Bench for operand_streamer: a ROWS=4/DEPTH=4 instance with a lane scoreboard,
// plus a DEPTH=1 instance for the single-word edge case.
module tb_operand_streamer;

   localparam int DW = 8;
   localparam int R  = 4;
   localparam int D  = 4;

   typedef struct {
      int         lane;
      logic [7:0] data;
   } sb_item_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic              read, clr, mem_en, done, busy;
   logic [1:0]        mem_addr;
   logic [R*DW-1:0]   mem_rdata, out_data;
   logic [R-1:0]      out_valid;

   logic              read1, clr1, mem_en1, done1, busy1;
   logic [0:0]        mem_addr1;
   logic [R*DW-1:0]   mem_rdata1, out_data1;
   logic [R-1:0]      out_valid1;

   int       n_checks = 0;
   int       n_fail   = 0;
   bit       sb_en    = 1'b0;
   sb_item_t sb [$];

   operand_streamer #(.DATA_W(DW), .ROWS(R), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .read(read), .clr(clr), .mem_en(mem_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid), .done(done), .busy(busy));

   operand_streamer #(.DATA_W(DW), .ROWS(R), .DEPTH(1)) dut1 (
      .clk(clk), .rst(rst), .read(read1), .clr(clr1), .mem_en(mem_en1), .mem_addr(mem_addr1),
      .mem_rdata(mem_rdata1), .out_data(out_data1), .out_valid(out_valid1), .done(done1), .busy(busy1));

   function automatic logic [R*DW-1:0] word(int k);
      logic [R*DW-1:0] w;
      for (int i = 0; i < R; i++) w[i*DW +: DW] = 8'(16*k + i);
      return w;
   endfunction

   // SRAM models: one-cycle read latency, junk on the bus when not enabled.
   always @(posedge clk) begin
      mem_rdata  <= mem_en  ? word(int'(mem_addr))  : $urandom;
      mem_rdata1 <= mem_en1 ? word(int'(mem_addr1)) : $urandom;
   end

   function automatic void push_pass();
      sb_item_t it;
      for (int c = 2; c <= D + R; c++)
         for (int i = 0; i < R; i++)
            if (c - 2 - i >= 0 && c - 2 - i < D) begin
               it.lane = i;
               it.data = 8'(16*(c - 2 - i) + i);
               sb.push_back(it);
            end
   endfunction

   always @(negedge clk) begin
      if (sb_en && !rst) begin
         for (int i = 0; i < R; i++) begin
            if (out_valid[i]) begin
               n_checks++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL sb_unexpected lane %0d got %h, required no valid", i, out_data[i*DW +: DW]);
               end else begin
                  sb_item_t e;
                  e = sb.pop_front();
                  if (e.lane !== i || e.data !== out_data[i*DW +: DW]) begin
                     n_fail++;
                     $display("FAIL sb_data lane %0d got %h, required lane %0d data %h", i,
                              out_data[i*DW +: DW], e.lane, e.data);
                  end
               end
            end else begin
               n_checks++;
               if (out_data[i*DW +: DW] !== 8'h00) begin
                  n_fail++;
                  $display("FAIL idle_lane_zero lane %0d got %h, required 00", i, out_data[i*DW +: DW]);
               end
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; read = 1'b0; clr = 1'b0; read1 = 1'b0; clr1 = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en got %b required 0", mem_en); end
      n_checks++; if (mem_addr !== 2'd0) begin n_fail++; $display("FAIL rst_mem_addr got %0d required 0", mem_addr); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data got %h required 0", out_data); end
      n_checks++; if (out_valid !== 4'h0) begin n_fail++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_done_busy got %b%b required 00", done, busy); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_nominal();
      logic [R-1:0] exp_v;
      sb_en = 1'b1;
      push_pass();
      read = 1'b1;
      for (int c = 0; c <= 9; c++) begin
         @(negedge clk);
         exp_v = '0;
         for (int i = 0; i < R; i++) if (c - 2 - i >= 0 && c - 2 - i < D) exp_v[i] = 1'b1;
         n_checks++; if (mem_en !== (c < D)) begin n_fail++; $display("FAIL nom_mem_en c%0d got %b required %b", c, mem_en, (c < D)); end
         n_checks++; if (mem_addr !== ((c < D) ? 2'(c) : 2'd0)) begin n_fail++; $display("FAIL nom_mem_addr c%0d got %0d required %0d", c, mem_addr, (c < D) ? c : 0); end
         n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL nom_valid c%0d got %b required %b", c, out_valid, exp_v); end
         n_checks++; if (done !== (c == 9)) begin n_fail++; $display("FAIL nom_done c%0d got %b required %b", c, done, (c == 9)); end
         n_checks++; if (busy !== (c <= 8)) begin n_fail++; $display("FAIL nom_busy c%0d got %b required %b", c, busy, (c <= 8)); end
         if (c >= 4 && c <= 7) begin
            n_checks++;
            if (out_data[23:16] !== 8'(16*(c - 4) + 2)) begin n_fail++; $display("FAIL nom_lane2 c%0d got %h required %h", c, out_data[23:16], 8'(16*(c - 4) + 2)); end
         end
         if (c == 8) begin
            n_checks++;
            if (out_data[31:24] !== 8'h33) begin n_fail++; $display("FAIL nom_lane3 got %h required 33", out_data[31:24]); end
         end
      end
   endtask

   task automatic test_hold_restart();
      for (int c = 10; c <= 14; c++) begin
         @(negedge clk);
         n_checks++; if (mem_en !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL hold_quiet c%0d got mem_en %b done %b required 0 0", c, mem_en, done); end
      end
      read = 1'b0;
      @(negedge clk);
      push_pass();
      read = 1'b1;
      for (int c = 0; c <= 9; c++) begin
         @(negedge clk);
         n_checks++; if (mem_addr !== ((c < D) ? 2'(c) : 2'd0) || mem_en !== (c < D)) begin n_fail++; $display("FAIL restart_addr c%0d got en %b addr %0d", c, mem_en, mem_addr); end
         n_checks++; if (done !== (c == 9)) begin n_fail++; $display("FAIL restart_done c%0d got %b required %b", c, done, (c == 9)); end
      end
      read = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drained got %0d left required 0", sb.size()); end
      sb_en = 1'b0;
   endtask

   task automatic test_clr_midpass();
      read = 1'b1;
      for (int c = 0; c <= 3; c++) @(negedge clk);
      n_checks++; if (mem_addr !== 2'd3) begin n_fail++; $display("FAIL clr_pre_addr got %0d required 3", mem_addr); end
      clr = 1'b1;
      @(negedge clk);
      n_checks++; if (mem_en !== 1'b0 || out_valid !== 4'h0) begin n_fail++; $display("FAIL clr_idle got en %b valid %b required 0 0", mem_en, out_valid); end
      n_checks++; if (done !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL clr_outputs got done %b busy %b data %h required zero", done, busy, out_data); end
      clr = 1'b0;
      @(negedge clk);
      n_checks++; if (mem_en !== 1'b1 || mem_addr !== 2'd0) begin n_fail++; $display("FAIL clr_restart got en %b addr %0d required 1 0", mem_en, mem_addr); end
      clr = 1'b1; read = 1'b0;
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL clr_final got busy %b en %b required 0 0", busy, mem_en); end
   endtask

   task automatic test_abort_drain();
      logic seen_done = 1'b0;
      read = 1'b1;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         seen_done |= done;
      end
      n_checks++; if (out_valid !== 4'hF) begin n_fail++; $display("FAIL abort_pre_valid got %b required 1111", out_valid); end
      read = 1'b0;
      @(negedge clk);
      n_checks++; if (out_valid !== 4'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_flush got valid %b busy %b required 0 0", out_valid, busy); end
      n_checks++; if (out_data !== '0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL abort_data got %h en %b required 0 0", out_data, mem_en); end
      for (int c = 0; c < 10; c++) begin
         seen_done |= done;
         @(negedge clk);
      end
      n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %b required 0", seen_done); end
   endtask

   task automatic test_depth1();
      logic [R-1:0] exp_v;
      read1 = 1'b1;
      for (int c = 0; c <= 7; c++) begin
         @(negedge clk);
         exp_v = (c >= 2 && c <= 5) ? 4'(1 << (c - 2)) : 4'h0;
         n_checks++; if (mem_en1 !== (c == 0)) begin n_fail++; $display("FAIL d1_mem_en c%0d got %b required %b", c, mem_en1, (c == 0)); end
         n_checks++; if (out_valid1 !== exp_v) begin n_fail++; $display("FAIL d1_valid c%0d got %b required %b", c, out_valid1, exp_v); end
         n_checks++; if (done1 !== (c == 6) || busy1 !== (c <= 5)) begin n_fail++; $display("FAIL d1_done_busy c%0d got %b%b required %b%b", c, done1, busy1, (c == 6), (c <= 5)); end
         if (c >= 2 && c <= 5) begin
            n_checks++;
            if (out_data1[(c-2)*DW +: DW] !== 8'(c - 2)) begin n_fail++; $display("FAIL d1_data c%0d got %h required %h", c, out_data1[(c-2)*DW +: DW], 8'(c - 2)); end
         end
      end
      read1 = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_async_reset();
      read = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (mem_en !== 1'b1 || mem_addr !== 2'd1) begin n_fail++; $display("FAIL ar_pre got en %b addr %0d required 1 1", mem_en, mem_addr); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (mem_en !== 1'b0 || mem_addr !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL ar_immediate got en %b addr %0d busy %b required 0 0 0", mem_en, mem_addr, busy); end
      n_checks++; if (out_valid !== 4'h0 || out_data !== '0 || done !== 1'b0) begin n_fail++; $display("FAIL ar_outputs got valid %b data %h done %b required zero", out_valid, out_data, done); end
      #1 rst = 1'b0;
      push_pass();
      sb_en = 1'b1;
      for (int c = 0; c <= 9; c++) begin
         @(negedge clk);
         n_checks++; if (mem_addr !== ((c < D) ? 2'(c) : 2'd0) || mem_en !== (c < D)) begin n_fail++; $display("FAIL ar_restart c%0d got en %b addr %0d", c, mem_en, mem_addr); end
         n_checks++; if (done !== (c == 9)) begin n_fail++; $display("FAIL ar_done c%0d got %b required %b", c, done, (c == 9)); end
      end
      read = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL ar_sb_drained got %0d left required 0", sb.size()); end
      sb_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_hold_restart();
      test_clr_midpass();
      test_abort_drain();
      test_depth1();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
